// File: rtl/lidar_frame_ctrl.sv
// lidar_frame_ctrl: captures one LiDAR frame of FRAME_LEN samples per start request and forwards it through a single output register
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       one-cycle request to capture a frame (ignored while busy)
//   abort       one-cycle request to drop the current frame and return to idle
//   in_data     incoming sample, qualified by in_valid, accepted when in_ready
//   out_data    forwarded sample, qualified by out_valid, consumed when out_ready
//   out_sof     first sample of the frame
//   out_eof     last sample of the frame
//   busy        controller is not idle
//   done        one-cycle pulse when a complete frame has drained
//   timeout_err one-cycle pulse when the sample stream stalls too long inside a frame
//   drop_count  saturating count of samples offered while not capturing
module lidar_frame_ctrl #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 64,
    parameter int TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eof,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [15:0]       drop_count
);
    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;
    localparam logic [15:0] LAST_IDX   = 16'(FRAME_LEN - 1);
    // idle count value whose increment would reach TIMEOUT-1
    localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT - 2);
    state_t            r_state;
    logic [15:0]       r_index;
    logic [15:0]       r_idle;
    logic              r_timed_out;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_sof;
    logic              r_out_eof;
    logic              r_busy;
    logic              r_done;
    logic              r_timeout_err;
    logic [15:0]       r_drop_count;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_drain;
    logic              w_drop;
    logic              w_timeout;
    logic              w_last;
    // output register can take a new sample when empty or being emptied this cycle
    assign w_in_ready = (r_state == CAPTURE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_drain    = !r_out_valid || out_ready;
    assign w_drop     = in_valid && ((r_state == IDLE) || (r_state == DONE));
    assign w_timeout  = (r_state == CAPTURE) && !w_accept && (r_idle == IDLE_LIMIT);
    assign w_last     = (r_index == LAST_IDX);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_index       <= 16'd0;
            r_idle        <= 16'd0;
            r_timed_out   <= 1'b0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_out_sof     <= 1'b0;
            r_out_eof     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_drop_count  <= 16'd0;
        end else begin
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            if (w_drop && (r_drop_count != 16'hFFFF))
                r_drop_count <= r_drop_count + 16'd1;
            if (abort) begin
                r_state     <= IDLE;
                r_busy      <= 1'b0;
                r_out_valid <= 1'b0;
                r_index     <= 16'd0;
                r_idle      <= 16'd0;
                r_timed_out <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_state     <= CAPTURE;
                            r_busy      <= 1'b1;
                            r_index     <= 16'd0;
                            r_idle      <= 16'd0;
                            r_timed_out <= 1'b0;
                        end
                    end
                    CAPTURE: begin
                        if (w_accept) begin
                            r_out_data  <= in_data;
                            r_out_valid <= 1'b1;
                            r_out_sof   <= (r_index == 16'd0);
                            r_out_eof   <= w_last;
                            r_index     <= w_last ? 16'd0 : r_index + 16'd1;
                            r_idle      <= 16'd0;
                            r_state     <= w_last ? FLUSH : CAPTURE;
                        end else begin
                            r_out_valid <= r_out_valid && !out_ready;
                            r_idle      <= r_idle + 16'd1;
                            if (w_timeout) begin
                                r_timeout_err <= 1'b1;
                                r_timed_out   <= 1'b1;
                                r_state       <= FLUSH;
                            end
                        end
                    end
                    FLUSH: begin
                        r_out_valid <= r_out_valid && !out_ready;
                        // a timed-out partial frame returns straight to idle without done
                        if (w_drain) begin
                            r_state <= r_timed_out ? IDLE : DONE;
                            r_done  <= !r_timed_out;
                            r_busy  <= !r_timed_out;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
    assign in_ready    = w_in_ready;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_sof     = r_out_sof;
    assign out_eof     = r_out_eof;
    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_timeout_err;
    assign drop_count  = r_drop_count;
endmodule

// File: tb/tb_lidar_frame_ctrl.sv
// tb_lidar_frame_ctrl: self-checking bench for lidar_frame_ctrl with FRAME_LEN=4, TIMEOUT=8
module tb_lidar_frame_ctrl;
    localparam int DW = 16;
    localparam int FL = 4;
    localparam int TO = 8;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_sof;
    logic          out_eof;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic [15:0]   drop_count;
    int            errors = 0;
    int            checks = 0;
    int            n_done = 0;
    int            n_to = 0;
    logic [17:0]   obs[$];

    lidar_frame_ctrl #(.DATA_W(DW), .FRAME_LEN(FL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .done(done),
        .timeout_err(timeout_err), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) n_done++;
        if (timeout_err) n_to++;
        if (out_valid && out_ready) obs.push_back({out_eof, out_sof, out_data});
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cyc;
        cyc;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if ({out_sof, out_eof} !== 2'b00) begin errors++; $display("FAIL reset_sof_eof: got %b want 00", {out_sof, out_eof}); end
        checks++; if ({busy, done, timeout_err} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", {busy, done, timeout_err}); end
        checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
        rst_n = 1'b1;
        cyc;
    endtask

    task automatic test_basic_frame;
        int d0;
        d0 = n_done;
        start = 1'b1;
        cyc;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        out_ready = 1'b1;
        for (int i = 0; i < FL; i++) begin
            in_valid = 1'b1;
            in_data = 16'(10 + i);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready[%0d]: got %b want 1", i, in_ready); end
            cyc;
            checks++; if (out_valid !== 1'b1 || out_data !== 16'(10 + i)) begin errors++; $display("FAIL basic_out[%0d]: got v=%b d=%0d want v=1 d=%0d", i, out_valid, out_data, 10 + i); end
            checks++; if (out_sof !== (i == 0) || out_eof !== (i == FL - 1)) begin errors++; $display("FAIL basic_sof_eof[%0d]: got %b%b want %b%b", i, out_sof, out_eof, i == 0, i == FL - 1); end
        end
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_flush_in_ready: got %b want 0", in_ready); end
        cyc;
        checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_done: got done=%b v=%b want done=1 v=0", done, out_valid); end
        cyc;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got done=%b busy=%b want 0 0", done, busy); end
        checks++; if (n_done !== d0 + 1) begin errors++; $display("FAIL basic_done_count: got %0d want %0d", n_done - d0, 1); end
    endtask

    task automatic test_backpressure;
        obs.delete();
        start = 1'b1;
        cyc;
        start = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 16'd10;
        cyc;
        in_data = 16'd11;
        cyc;
        out_ready = 1'b0;
        in_data = 16'd12;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
            cyc;
            checks++; if (out_valid !== 1'b1 || out_data !== 16'd11) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%0d want v=1 d=11", k, out_valid, out_data); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b want 1", in_ready); end
        cyc;
        in_data = 16'd13;
        cyc;
        in_valid = 1'b0;
        cyc;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", done); end
        cyc;
        checks++; if (obs.size() !== FL) begin errors++; $display("FAIL bp_count: got %0d want %0d", obs.size(), FL); end
        for (int i = 0; i < FL && i < obs.size(); i++) begin
            checks++; if (obs[i] !== {i == FL - 1, i == 0, 16'(10 + i)}) begin errors++; $display("FAIL bp_seq[%0d]: got %h want %h", i, obs[i], {i == FL - 1, i == 0, 16'(10 + i)}); end
        end
    endtask

    task automatic test_timeout;
        int d0, t0;
        obs.delete();
        d0 = n_done;
        t0 = n_to;
        start = 1'b1;
        cyc;
        start = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 16'h55;
        cyc;
        in_data = 16'h56;
        cyc;
        in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc;
            checks++; if (timeout_err !== (k == TO - 1)) begin errors++; $display("FAIL to_pulse[%0d]: got %b want %b", k, timeout_err, k == TO - 1); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got busy=%b want 0", busy); end
        checks++; if (n_done !== d0 || n_to !== t0 + 1) begin errors++; $display("FAIL to_counts: got done=%0d to=%0d want 0 1", n_done - d0, n_to - t0); end
        checks++; if (obs.size() !== 2 || obs[0][17] !== 1'b0 || obs[1][17] !== 1'b0) begin errors++; $display("FAIL to_partial: got n=%0d want 2 samples without eof", obs.size()); end
    endtask

    task automatic test_abort;
        int d0, t0;
        d0 = n_done;
        t0 = n_to;
        start = 1'b1;
        cyc;
        start = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 16'd20;
        cyc;
        in_data = 16'd21;
        cyc;
        in_data = 16'd22;
        abort = 1'b1;
        cyc;
        abort = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got v=%b busy=%b want 0 0", out_valid, busy); end
        cyc;
        cyc;
        checks++; if (n_done !== d0 || n_to !== t0) begin errors++; $display("FAIL abort_no_pulse: got done=%0d to=%0d want 0 0", n_done - d0, n_to - t0); end
        start = 1'b1;
        cyc;
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 16'd30;
        cyc;
        checks++; if (out_sof !== 1'b1 || out_data !== 16'd30) begin errors++; $display("FAIL abort_restart_sof: got sof=%b d=%0d want 1 30", out_sof, out_data); end
        for (int i = 1; i < FL; i++) begin
            in_data = 16'(30 + i);
            cyc;
        end
        in_valid = 1'b0;
        cyc;
        cyc;
        checks++; if (busy !== 1'b0 || n_done !== d0 + 1) begin errors++; $display("FAIL abort_restart_done: got busy=%b done=%0d want 0 1", busy, n_done - d0); end
    endtask

    task automatic test_random;
        logic [17:0] hold[$];
        int n, gap, pct, d0;
        bit cap, exp_ir, acc, pop, exp_to, timed;
        for (int f = 0; f < 30; f++) begin
            pct = (f % 3 == 2) ? 15 : 80;
            d0 = n_done;
            in_valid = 1'b0;
            start = 1'b1;
            cyc;
            start = 1'b0;
            cap = 1;
            n = 0;
            gap = 0;
            timed = 0;
            hold.delete();
            for (int c = 0; c < 500 && cap; c++) begin
                in_valid = ($urandom_range(99) < pct);
                in_data = 16'($urandom);
                out_ready = ($urandom_range(99) < 75);
                #1;
                exp_ir = (hold.size() == 0) || out_ready;
                checks++; if (in_ready !== exp_ir) begin errors++; $display("FAIL rnd_in_ready[f%0d c%0d]: got %b want %b", f, c, in_ready, exp_ir); end
                acc = in_valid && exp_ir;
                pop = (hold.size() != 0) && out_ready;
                cyc;
                if (pop) void'(hold.pop_front());
                exp_to = 0;
                if (acc) begin
                    hold.push_back({n == FL - 1, n == 0, in_data});
                    n++;
                    gap = 0;
                    cap = (n < FL);
                end else begin
                    gap++;
                    if (gap == TO - 1) begin
                        exp_to = 1;
                        cap = 0;
                        timed = 1;
                    end
                end
                checks++; if (timeout_err !== exp_to) begin errors++; $display("FAIL rnd_timeout[f%0d c%0d]: got %b want %b", f, c, timeout_err, exp_to); end
                checks++; if (out_valid !== (hold.size() != 0)) begin errors++; $display("FAIL rnd_out_valid[f%0d c%0d]: got %b want %b", f, c, out_valid, hold.size() != 0); end
                if (hold.size() != 0) begin
                    checks++; if ({out_eof, out_sof, out_data} !== hold[0]) begin errors++; $display("FAIL rnd_out[f%0d c%0d]: got %h want %h", f, c, {out_eof, out_sof, out_data}, hold[0]); end
                end
            end
            in_valid = 1'b0;
            for (int c = 0; c < 20 && busy; c++) begin
                out_ready = 1'($urandom_range(1));
                pop = (hold.size() != 0) && out_ready;
                cyc;
                if (pop) void'(hold.pop_front());
                checks++; if (out_valid !== (hold.size() != 0)) begin errors++; $display("FAIL rnd_drain_valid[f%0d]: got %b want %b", f, out_valid, hold.size() != 0); end
                if (hold.size() != 0) begin
                    checks++; if ({out_eof, out_sof, out_data} !== hold[0]) begin errors++; $display("FAIL rnd_drain_out[f%0d]: got %h want %h", f, {out_eof, out_sof, out_data}, hold[0]); end
                end
            end
            checks++; if (busy !== 1'b0 || hold.size() != 0) begin errors++; $display("FAIL rnd_end[f%0d]: got busy=%b left=%0d want 0 0", f, busy, hold.size()); end
            checks++; if (n_done - d0 !== (timed ? 0 : 1)) begin errors++; $display("FAIL rnd_done[f%0d]: got %0d want %0d", f, n_done - d0, timed ? 0 : 1); end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_frame;
        int d0, t0;
        start = 1'b1;
        cyc;
        start = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 16'd40;
        cyc;
        in_data = 16'd41;
        cyc;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_async: got busy=%b v=%b want 0 0", busy, out_valid); end
        cyc;
        rst_n = 1'b1;
        d0 = n_done;
        t0 = n_to;
        for (int k = 0; k < 12; k++) cyc;
        checks++; if (n_done !== d0 || n_to !== t0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_after: got done=%0d to=%0d busy=%b want 0 0 0", n_done - d0, n_to - t0, busy); end
    endtask

    task automatic test_drop_count;
        int n;
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL drop_start: got %0d want 0", drop_count); end
        in_valid = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            cyc;
            n++;
        end
        checks++; if (drop_count !== 16'(n)) begin errors++; $display("FAIL drop_five: got %0d want %0d", drop_count, n); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got rdy=%b busy=%b want 0 0", in_ready, busy); end
        while (n < 65534) begin
            cyc;
            n++;
        end
        checks++; if (drop_count !== 16'd65534) begin errors++; $display("FAIL drop_near_max: got %0d want 65534", drop_count); end
        for (int k = 0; k < 6; k++) begin
            cyc;
            n++;
        end
        checks++; if (drop_count !== 16'((n > 65535) ? 65535 : n)) begin errors++; $display("FAIL drop_saturate: got %0d want 65535", drop_count); end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic_frame;
        test_backpressure;
        test_timeout;
        test_abort;
        test_random;
        test_reset_mid_frame;
        test_drop_count;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
